// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Digit-serial adder/subtractor. Processes WIDTH-bit operands
//                DIGIT bits per clock, LSB first, with a registered carry
//                between digits. Valid/ready handshakes on both sides. Reports
//                carry-out (no-borrow for subtraction) and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             car,
    output logic             ovf,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_STEPS = WIDTH / DIGIT;
    // A single-step configuration still needs a 1-bit counter to stay legal.
    localparam int c_CNT_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_addsub: WIDTH must be at least 2");
        end
        if (DIGIT < 1) begin : g_bad_digit_min
            $error("serial_addsub: DIGIT must be at least 1");
        end
        if ((DIGIT >= 1) && ((WIDTH % DIGIT) != 0)) begin : g_bad_digit_div
            $error("serial_addsub: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_opa;      // operand A, consumed LSB first
    logic [WIDTH-1:0]   r_opb;      // effective operand B (inverted for sub)
    logic [WIDTH-1:0]   r_res;      // result digits shift in from the top
    logic               r_carry;    // carry between digits
    logic               r_sign_a;   // sign of A captured at accept
    logic               r_sign_b;   // sign of effective B captured at accept
    logic [c_CNT_W-1:0] r_cnt;      // digit index within RUN
    logic [WIDTH-1:0]   r_out;
    logic               r_car;
    logic               r_ovf;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_accept;
    logic               w_last;
    logic [DIGIT:0]     w_sum;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_ovf_next;
    logic [WIDTH-1:0]   w_opb_eff;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_state == S_RUN) && (r_cnt == c_LAST);
    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
    assign w_opb_eff = sub ? ~in2 : in2;

    // One digit of the sum, one bit wider to expose the carry out of the digit.
    assign w_sum = {1'b0, r_opa[DIGIT-1:0]}
                 + {1'b0, r_opb[DIGIT-1:0]}
                 + (DIGIT+1)'(r_carry);

    // The new digit enters at the top; when one digit spans the whole word
    // there is nothing left of the old result to keep.
    generate
        if (DIGIT == WIDTH) begin : g_res_full
            assign w_res_next = w_sum[DIGIT-1:0];
        end else begin : g_res_part
            assign w_res_next = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Overflow only when both effective operands share a sign that the
    // result does not.
    assign w_ovf_next = (r_sign_a == r_sign_b) & (w_res_next[WIDTH-1] != r_sign_a);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture at accept, then digit-serial shift/add during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_opa    <= in1;
            r_opb    <= w_opb_eff;
            r_res    <= '0;
            r_carry  <= sub ? 1'b1 : cin;
            r_sign_a <= in1[WIDTH-1];
            r_sign_b <= w_opb_eff[WIDTH-1];
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_opa   <= r_opa >> DIGIT;
            r_opb   <= r_opb >> DIGIT;
            r_res   <= w_res_next;
            r_carry <= w_sum[DIGIT];
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end

    // Result registers load on the final digit and hold until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_car <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_out <= w_res_next;
            r_car <= w_sum[DIGIT];
            r_ovf <= w_ovf_next;
        end
    end

    assign out = r_out;
    assign car = r_car;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Self-checking bench for serial_addsub (DIGIT=1 and DIGIT=4
//                instances, WIDTH=8) with a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    typedef struct packed {
        logic [7:0] out;
        logic       car;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       cin;
    logic       sub;
    logic       out_ready;

    logic       in_valid1, in_ready1, out_valid1, car1, ovf1, busy1;
    logic [7:0] out1;
    logic       in_valid4, in_ready4, out_valid4, car4, ovf4, busy4;
    logic [7:0] out4;

    exp_t q1[$];
    exp_t q4[$];

    int n_vec;
    int n_miss;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out       (out1),
        .car       (car1),
        .ovf       (ovf1),
        .busy      (busy1)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out       (out4),
        .car       (car4),
        .ovf       (ovf4),
        .busy      (busy4)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: 9-bit sum of A and effective B.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic s);
        logic [8:0] sum;
        logic [7:0] beff;
        exp_t       e;
        beff  = s ? ~b : b;
        sum   = {1'b0, a} + {1'b0, beff} + {8'd0, (s ? 1'b1 : c)};
        e.out = sum[7:0];
        e.car = sum[8];
        e.ovf = (a[7] == beff[7]) && (sum[7] != a[7]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        in1 = 8'($urandom);
        in2 = 8'($urandom);
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
    endtask

    // One operation on the DIGIT=1 instance, with 'hold' cycles of backpressure.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input int hold);
        int   n;
        exp_t e;
        exp_t snap;
        n = 0;
        while (!in_ready1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(in_ready1), 32'd1);
        in1 = a; in2 = b; cin = c; sub = s; in_valid1 = 1'b1;
        @(posedge clk);
        q1.push_back(model(a, b, c, s));
        #1;
        in_valid1 = 1'b0;
        scramble();
        chk("busy_run", 32'(busy1), 32'd1);
        chk("in_ready_run", 32'(in_ready1), 32'd0);
        n = 0;
        while (!out_valid1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'd8);
        snap = '{out: out1, car: car1, ovf: ovf1};
        repeat (hold) begin
            @(posedge clk); #1;
            scramble();
            chk("hold_valid", 32'(out_valid1), 32'd1);
            chk("hold_in_ready", 32'(in_ready1), 32'd0);
            chk("hold_stable", 32'({out1, car1, ovf1}), 32'(snap));
        end
        e = q1.pop_front();
        chk("out", 32'(out1), 32'(e.out));
        chk("car", 32'(car1), 32'(e.car));
        chk("ovf", 32'(ovf1), 32'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid1), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready1), 32'd1);
    endtask

    // Directed sequence
    initial begin
        int   n;
        exp_t e;
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
        in1 = 8'd0; in2 = 8'd0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready1), 32'd1);
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_out", 32'({out1, car1, ovf1}), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b1, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 5);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 2);

        // Abort an operation at RUN digit 3 with an asynchronous reset.
        in1 = 8'hA5; in2 = 8'h5A; cin = 1'b1; sub = 1'b0; in_valid1 = 1'b1;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy1), 32'd0);
        chk("async_in_ready", 32'(in_ready1), 32'd1);
        chk("async_out_valid", 32'(out_valid1), 32'd0);
        chk("async_out", 32'({out1, car1, ovf1}), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid1) n++;
        end
        chk("aborted_no_output", 32'(n), 32'd0);
        run_op(8'h33, 8'h44, 1'b0, 1'b1, 0);

        // DIGIT=4 instance: two RUN cycles.
        in1 = 8'hC8; in2 = 8'h64; cin = 1'b0; sub = 1'b0; in_valid4 = 1'b1;
        @(posedge clk);
        q4.push_back(model(8'hC8, 8'h64, 1'b0, 1'b0));
        #1 in_valid4 = 1'b0;
        scramble();
        n = 0;
        while (!out_valid4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("d4_latency", 32'(n), 32'd2);
        e = q4.pop_front();
        chk("d4_out", 32'(out4), 32'(e.out));
        chk("d4_car", 32'(car4), 32'(e.car));
        chk("d4_ovf", 32'(ovf4), 32'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("d4_in_ready", 32'(in_ready4), 32'd1);

        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q4_empty", 32'(q4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
